// File: rtl/accel_if.sv
// Signal bundle between the accelerator job sequencer and its neighbours:
// data buffer, MAC array, result FIFO and the control/status registers.
interface accel_if #(
  parameter int ARRAY_DIM = 4
);
  localparam int WROW_W = (ARRAY_DIM > 1) ? $clog2(ARRAY_DIM) : 1;

  logic              start;
  logic              clear;
  logic [7:0]        job_len;
  logic              buf_empty;
  logic              buf_is_weight;
  logic              out_pop;
  logic              buf_pop;
  logic              weight_load;
  logic [WROW_W-1:0] weight_row;
  logic              array_en;
  logic              res_capture;
  logic              out_flush;
  logic              busy;
  logic              done;
  logic [2:0]        err;

  modport master (
    input  start, clear, job_len, buf_empty, buf_is_weight, out_pop,
    output buf_pop, weight_load, weight_row, array_en, res_capture,
           out_flush, busy, done, err
  );

  modport slave (
    output start, clear, job_len, buf_empty, buf_is_weight, out_pop,
    input  buf_pop, weight_load, weight_row, array_en, res_capture,
           out_flush, busy, done, err
  );
endinterface

// File: rtl/accel_controller.sv
// Job sequencer: loads ARRAY_DIM weight rows, streams job_len input vectors
// through the MAC array under result-FIFO credit control, reports status.
module accel_controller #(
  parameter int ARRAY_DIM = 4,
  parameter int PIPE_LAT  = 6,
  parameter int OUT_DEPTH = 4
) (
  input  logic    clk,
  input  logic    n_rst,
  accel_if.master bus
);
  localparam int WROW_W = (ARRAY_DIM > 1) ? $clog2(ARRAY_DIM) : 1;
  localparam int CRD_W  = $clog2(OUT_DEPTH + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD_W  = 3'd1,
    S_COMPUTE = 3'd2,
    S_DRAIN   = 3'd3,
    S_DONE    = 3'd4,
    S_ERR     = 3'd5
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [7:0]          r_job_len;
  logic [WROW_W-1:0]   r_w_cnt;
  logic [7:0]          r_issued;
  logic [CRD_W-1:0]    r_credits;
  logic [PIPE_LAT-1:0] r_pipe;
  logic [PIPE_LAT-1:0] w_pipe_in;
  logic [PIPE_LAT-1:0] w_pipe_tail;
  logic                r_busy;
  logic                r_done;
  logic [2:0]          r_err;
  logic                r_out_flush;
  logic                w_buf_pop;
  logic                w_weight_load;
  logic                w_array_en;
  logic [2:0]          w_err_set;
  logic                w_head_w;
  logic                w_head_in;
  logic                w_credit_ok;
  logic                w_cr_dec;
  logic                w_accept;

  assign w_head_w    = !bus.buf_empty && bus.buf_is_weight;
  assign w_head_in   = !bus.buf_empty && !bus.buf_is_weight;
  assign w_credit_ok = r_credits < CRD_W'(OUT_DEPTH);
  assign w_cr_dec    = bus.out_pop && (r_credits != {CRD_W{1'b0}});
  assign w_accept    = (r_state == S_IDLE) && bus.start && (bus.job_len != 8'd0);
  // pipe bit 0 is the oldest entry; "empty" means nothing left behind it
  assign w_pipe_tail = r_pipe >> 1;

  // next-state and same-cycle buffer/array strobes
  always_comb begin
    w_next        = r_state;
    w_buf_pop     = 1'b0;
    w_weight_load = 1'b0;
    w_array_en    = 1'b0;
    w_err_set     = 3'b000;
    if (bus.clear) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start && (bus.job_len == 8'd0)) begin
            w_err_set[1] = 1'b1;
            w_next       = S_ERR;
          end else if (bus.start) begin
            w_next = S_LOAD_W;
          end else begin
            w_next = S_IDLE;
          end
        end
        S_LOAD_W: begin
          if (w_head_w) begin
            w_buf_pop     = 1'b1;
            w_weight_load = 1'b1;
            w_next = (r_w_cnt == WROW_W'(ARRAY_DIM - 1)) ? S_COMPUTE : S_LOAD_W;
          end else if (w_head_in) begin
            w_err_set[0] = 1'b1;
            w_next       = S_ERR;
          end else begin
            w_next = S_LOAD_W;
          end
        end
        S_COMPUTE: begin
          if (w_head_in && w_credit_ok) begin
            w_buf_pop  = 1'b1;
            w_array_en = 1'b1;
            w_next = (r_issued == (r_job_len - 8'd1)) ? S_DRAIN : S_COMPUTE;
          end else if (w_head_w) begin
            w_err_set[0] = 1'b1;
            w_next       = S_ERR;
          end else begin
            w_next = S_COMPUTE;
          end
        end
        S_DRAIN: begin
          if (w_pipe_tail == {PIPE_LAT{1'b0}}) begin
            w_next = S_DONE;
          end else begin
            w_next = S_DRAIN;
          end
        end
        S_DONE:  w_next = S_IDLE;
        S_ERR:   w_next = S_ERR;
        default: w_next = S_IDLE;
      endcase
      if (r_busy && bus.start) begin
        w_err_set[2] = 1'b1;
      end else begin
        w_err_set[2] = w_err_set[2];
      end
    end
  end

  // new valid bit enters at the far end of the pipe
  always_comb begin
    w_pipe_in             = {PIPE_LAT{1'b0}};
    w_pipe_in[PIPE_LAT-1] = w_array_en;
  end

  // state, counters, credits, valid pipe and sticky status
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_state     <= S_IDLE;
      r_job_len   <= 8'd0;
      r_w_cnt     <= {WROW_W{1'b0}};
      r_issued    <= 8'd0;
      r_credits   <= {CRD_W{1'b0}};
      r_pipe      <= {PIPE_LAT{1'b0}};
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 3'b000;
      r_out_flush <= 1'b0;
    end else if (bus.clear) begin
      r_state     <= S_IDLE;
      r_job_len   <= r_job_len;
      r_w_cnt     <= {WROW_W{1'b0}};
      r_issued    <= 8'd0;
      r_credits   <= {CRD_W{1'b0}};
      r_pipe      <= {PIPE_LAT{1'b0}};
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 3'b000;
      r_out_flush <= 1'b1;
    end else begin
      r_state     <= w_next;
      r_busy      <= (w_next == S_LOAD_W) || (w_next == S_COMPUTE) || (w_next == S_DRAIN);
      r_err       <= r_err | w_err_set;
      r_out_flush <= (w_next == S_ERR) && (r_state != S_ERR);
      if (w_next == S_ERR) begin
        r_pipe <= {PIPE_LAT{1'b0}};
      end else if (r_state != S_ERR) begin
        r_pipe <= w_pipe_tail | w_pipe_in;
      end else begin
        r_pipe <= r_pipe;
      end
      case ({w_array_en, w_cr_dec})
        2'b10:   r_credits <= r_credits + CRD_W'(1);
        2'b01:   r_credits <= r_credits - CRD_W'(1);
        default: r_credits <= r_credits;
      endcase
      if (w_accept) begin
        r_job_len <= bus.job_len;
        r_done    <= 1'b0;
        r_w_cnt   <= {WROW_W{1'b0}};
        r_issued  <= 8'd0;
      end else begin
        r_job_len <= r_job_len;
        r_done    <= r_done | (r_state == S_DONE);
        if ((r_state == S_LOAD_W) && (w_next == S_COMPUTE)) begin
          r_w_cnt <= {WROW_W{1'b0}};
        end else if (w_weight_load) begin
          r_w_cnt <= r_w_cnt + WROW_W'(1);
        end else begin
          r_w_cnt <= r_w_cnt;
        end
        r_issued <= w_array_en ? (r_issued + 8'd1) : r_issued;
      end
    end
  end

  assign bus.buf_pop     = w_buf_pop;
  assign bus.weight_load = w_weight_load;
  assign bus.weight_row  = w_weight_load ? r_w_cnt : {WROW_W{1'b0}};
  assign bus.array_en    = w_array_en;
  assign bus.res_capture = r_pipe[0];
  assign bus.out_flush   = r_out_flush;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.err         = r_err;
endmodule

// File: tb/tb_accel_controller.sv
// Scoreboard bench for accel_controller: stimulus pushes expected event cycles
// and status snapshots; a negedge monitor pops and compares them.
module tb_accel_controller;
  localparam int ARRAY_DIM = 4;
  localparam int PIPE_LAT  = 6;
  localparam int OUT_DEPTH = 4;
  localparam logic [11:0] M_STAT = 12'hF80;
  localparam logic [11:0] M_POP  = 12'h040;
  localparam logic [11:0] M_ALL  = 12'hFFF;

  typedef struct { int cyc; int row; } wl_t;
  typedef struct { int cyc; logic [11:0] exp; logic [11:0] mask; int id; } st_t;

  logic clk = 1'b0;
  logic n_rst;
  logic buf_clr;
  logic tags [0:255];
  int   rd = 0;
  int   wr = 0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   mon_on = 1'b0;
  bit   end_req = 1'b0;
  bit   end_ack = 1'b0;

  wl_t q_wl[$];
  int  q_en[$];
  int  q_cap[$];
  int  q_fl[$];
  st_t q_st[$];

  accel_if #(.ARRAY_DIM(ARRAY_DIM)) bus ();

  accel_controller #(
    .ARRAY_DIM(ARRAY_DIM),
    .PIPE_LAT (PIPE_LAT),
    .OUT_DEPTH(OUT_DEPTH)
  ) dut (
    .clk  (clk),
    .n_rst(n_rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // data buffer model: a tag FIFO the DUT pops from
  always @(posedge clk) begin
    if (buf_clr) rd <= wr;
    else if (bus.buf_pop) rd <= rd + 1;
  end

  assign bus.buf_empty     = (rd == wr);
  assign bus.buf_is_weight = tags[rd[7:0]];

  function automatic void cmp(input string name, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, want, cyc);
    end
  endfunction

  function automatic logic [11:0] st(input logic busy, input logic done, input logic [2:0] err);
    return {busy, done, err, 7'd0};
  endfunction

  // monitor: pops the expected event/status queues whenever the DUT presents something
  initial begin
    logic [11:0] obs;
    wl_t w;
    forever begin
      @(negedge clk);
      if (mon_on) begin
        obs = {bus.busy, bus.done, bus.err, bus.buf_pop, bus.weight_load, bus.array_en,
               bus.res_capture, bus.out_flush, bus.weight_row};
        if (bus.weight_load) begin
          if (q_wl.size() == 0) cmp("weight_load_unexpected", cyc, -1);
          else begin
            w = q_wl.pop_front();
            cmp("weight_load_cycle", cyc, w.cyc);
            cmp("weight_row", int'(bus.weight_row), w.row);
          end
        end
        if (bus.array_en) begin
          if (q_en.size() == 0) cmp("array_en_unexpected", cyc, -1);
          else cmp("array_en_cycle", cyc, q_en.pop_front());
        end
        if (bus.res_capture) begin
          if (q_cap.size() == 0) cmp("res_capture_unexpected", cyc, -1);
          else cmp("res_capture_cycle", cyc, q_cap.pop_front());
        end
        if (bus.out_flush) begin
          if (q_fl.size() == 0) cmp("out_flush_unexpected", cyc, -1);
          else cmp("out_flush_cycle", cyc, q_fl.pop_front());
        end
        for (int i = q_st.size() - 1; i >= 0; i--) begin
          if (q_st[i].cyc <= cyc) begin
            n_cmp++;
            if ((q_st[i].cyc < cyc) || (((obs ^ q_st[i].exp) & q_st[i].mask) != 12'd0)) begin
              n_bad++;
              $display("FAIL status%0d at cycle %0d: got %03h, expected %03h under mask %03h",
                       q_st[i].id, q_st[i].cyc, obs, q_st[i].exp, q_st[i].mask);
            end
            q_st.delete(i);
          end
        end
        if (end_req && !end_ack) begin
          cmp("pending_weight_load", q_wl.size(), 0);
          cmp("pending_array_en", q_en.size(), 0);
          cmp("pending_res_capture", q_cap.size(), 0);
          cmp("pending_out_flush", q_fl.size(), 0);
          cmp("pending_status", q_st.size(), 0);
          end_ack = 1'b1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_buf(input logic tag, input int n);
    for (int i = 0; i < n; i++) begin
      tags[wr[7:0]] = tag;
      wr = wr + 1;
    end
  endtask

  task automatic exp_weights(input int t);
    for (int i = 0; i < ARRAY_DIM; i++) q_wl.push_back('{t + 1 + i, i});
  endtask

  task automatic exp_en(input int c, input bit with_cap);
    q_en.push_back(c);
    if (with_cap) q_cap.push_back(c + PIPE_LAT);
  endtask

  task automatic exp_st(input int c, input logic [11:0] e, input logic [11:0] m, input int id);
    q_st.push_back('{c, e, m, id});
  endtask

  task automatic start_job(input logic [7:0] len);
    bus.start   = 1'b1;
    bus.job_len = len;
    tick();
    bus.start   = 1'b0;
  endtask

  task automatic do_clear(input int id);
    q_fl.push_back(cyc + 1);
    exp_st(cyc + 1, st(1'b0, 1'b0, 3'b000), M_STAT, id);
    bus.clear = 1'b1;
    buf_clr   = 1'b1;
    tick();
    bus.clear = 1'b0;
    buf_clr   = 1'b0;
  endtask

  initial begin
    int t;
    for (int i = 0; i < 256; i++) tags[i] = 1'b0;
    n_rst         = 1'b0;
    buf_clr       = 1'b0;
    bus.start     = 1'b0;
    bus.clear     = 1'b0;
    bus.job_len   = 8'd0;
    bus.out_pop   = 1'b0;
    repeat (3) tick();
    mon_on = 1'b1;
    exp_st(cyc, 12'd0, M_ALL, 0);
    tick();
    n_rst = 1'b1;
    tick();

    // nominal job: 4 weights, 3 inputs, result FIFO always drained
    push_buf(1'b1, 4);
    push_buf(1'b0, 3);
    bus.out_pop = 1'b1;
    t = cyc;
    exp_weights(t);
    exp_en(t + 5, 1'b1);
    exp_en(t + 6, 1'b1);
    exp_en(t + 7, 1'b1);
    exp_st(t + 3, st(1'b1, 1'b0, 3'b000), M_STAT, 1);
    exp_st(t + 15, st(1'b0, 1'b1, 3'b000), M_STAT, 2);
    start_job(8'd3);
    repeat (16) tick();

    // credit stall: 4 issues, stall, one pop releases exactly one more
    bus.out_pop = 1'b0;
    push_buf(1'b1, 4);
    push_buf(1'b0, 6);
    t = cyc;
    exp_weights(t);
    for (int i = 0; i < 4; i++) exp_en(t + 5 + i, 1'b1);
    exp_en(t + 15, 1'b1);
    exp_st(t + 10, st(1'b1, 1'b0, 3'b000), M_STAT | M_POP, 3);
    exp_st(t + 13, st(1'b1, 1'b0, 3'b000), M_STAT | M_POP, 4);
    exp_st(t + 17, st(1'b1, 1'b0, 3'b000), M_STAT | M_POP, 5);
    start_job(8'd6);
    repeat (13) tick();
    bus.out_pop = 1'b1;
    tick();
    bus.out_pop = 1'b0;
    repeat (7) tick();
    do_clear(6);

    // wrong tag during weight load
    push_buf(1'b1, 2);
    push_buf(1'b0, 1);
    t = cyc;
    q_wl.push_back('{t + 1, 0});
    q_wl.push_back('{t + 2, 1});
    q_fl.push_back(t + 4);
    exp_st(t + 5, st(1'b0, 1'b0, 3'b001), M_STAT | M_POP, 7);
    exp_st(t + 7, st(1'b0, 1'b0, 3'b001), M_STAT | M_POP, 8);
    start_job(8'd2);
    repeat (7) tick();
    do_clear(9);

    // zero-length start, then a job with a start arriving during COMPUTE
    t = cyc;
    q_fl.push_back(t + 1);
    exp_st(t + 2, st(1'b0, 1'b0, 3'b010), M_STAT, 10);
    start_job(8'd0);
    repeat (2) tick();
    do_clear(11);
    push_buf(1'b1, 4);
    push_buf(1'b0, 2);
    bus.out_pop = 1'b1;
    t = cyc;
    exp_weights(t);
    exp_en(t + 5, 1'b1);
    exp_en(t + 6, 1'b1);
    exp_st(t + 7, st(1'b1, 1'b0, 3'b100), M_STAT, 12);
    exp_st(t + 15, st(1'b0, 1'b1, 3'b100), M_STAT, 13);
    start_job(8'd2);
    repeat (4) tick();
    bus.start   = 1'b1;
    bus.job_len = 8'd9;
    tick();
    bus.start   = 1'b0;
    repeat (10) tick();
    do_clear(14);

    // buffer underrun for 5 cycles mid-COMPUTE; one spare input must stay unpopped
    push_buf(1'b1, 4);
    push_buf(1'b0, 1);
    t = cyc;
    exp_weights(t);
    exp_en(t + 5, 1'b1);
    exp_en(t + 11, 1'b1);
    exp_en(t + 12, 1'b1);
    exp_st(t + 8, st(1'b1, 1'b0, 3'b000), M_STAT | M_POP, 15);
    exp_st(t + 21, st(1'b0, 1'b1, 3'b000), M_STAT, 16);
    start_job(8'd3);
    repeat (10) tick();
    push_buf(1'b0, 3);
    repeat (11) tick();
    do_clear(17);

    // reset during DRAIN with two results in flight
    bus.out_pop = 1'b0;
    push_buf(1'b1, 4);
    push_buf(1'b0, 2);
    t = cyc;
    exp_weights(t);
    exp_en(t + 5, 1'b0);
    exp_en(t + 6, 1'b0);
    exp_st(t + 9, 12'd0, M_ALL, 18);
    start_job(8'd2);
    repeat (7) tick();
    n_rst = 1'b0;
    tick();
    n_rst = 1'b1;
    repeat (8) tick();

    // clear during DRAIN, then the next job must see a full credit window
    push_buf(1'b1, 4);
    push_buf(1'b0, 2);
    t = cyc;
    exp_weights(t);
    exp_en(t + 5, 1'b0);
    exp_en(t + 6, 1'b0);
    start_job(8'd2);
    repeat (7) tick();
    do_clear(19);
    repeat (6) tick();
    push_buf(1'b1, 4);
    push_buf(1'b0, 6);
    t = cyc;
    exp_weights(t);
    for (int i = 0; i < 4; i++) exp_en(t + 5 + i, 1'b1);
    exp_st(t + 12, st(1'b1, 1'b0, 3'b000), M_STAT | M_POP, 20);
    start_job(8'd6);
    repeat (15) tick();
    do_clear(21);
    repeat (2) tick();

    end_req = 1'b1;
    for (int k = 0; k < 5 && !end_ack; k++) tick();
    if (!end_ack) begin
      $display("FAIL end_check: monitor did not acknowledge within 5 cycles");
      $fatal(1);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/accel_controller.md
# accel_controller

Job sequencer for the AI accelerator datapath: it sits between the AHB subordinate's data buffer and the MAC array. It takes a start command and a job length from the control register. It then drains weight words into the array row by row and streams input vectors through the array. Output credits are tracked so the result FIFO can never overflow, and busy/done/error status is reported back for the status and error registers.

## Interface
- ARRAY_DIM, 4: weight rows per job (number of weight words consumed before compute)
- PIPE_LAT, 6: cycles from array_en to the result being valid at the array output (≥1)
- OUT_DEPTH, 4: result FIFO depth (credit limit)

- clk  in  1  system clock
- n_rst  in  1  reset; synchronous, active-low
- start  in  1  one-cycle job start pulse (ctrl_reg start bit)
- clear  in  1  one-cycle abort/error clear
- job_len  in  8  number of input vectors in the job, sampled on accepted start
- buf_empty  in  1  data buffer empty
- buf_is_weight  in  1  tag of the buffer head word (1 = weight, 0 = input)
- out_pop  in  1  result FIFO read (AHB read of output_data)
- buf_pop  out  1  pop the buffer head word this cycle
- weight_load  out  1  load the head word into array row weight_row
- weight_row  out  $clog2(ARRAY_DIM)  target row for weight_load
- array_en  out  1  present the head word to the array as an input vector
- res_capture  out  1  write the array output into the result FIFO
- out_flush  out  1  flush the result FIFO (pulse)
- busy  out  1  job in progress
- done  out  1  sticky job-complete flag
- err  out  3  sticky error flags: [0] wrong tag at the buffer head, [1] job_len==0 at start, [2] start while busy

## Operation
- States: IDLE, LOAD_W, COMPUTE, DRAIN, DONE, ERR.
- IDLE
  - start with job_len≠0: latch job_len, clear done, clear w_cnt/issued, go to LOAD_W.
  - start with job_len==0: set err[1], go to ERR.
- LOAD_W
  - When !buf_empty && buf_is_weight: assert buf_pop and weight_load, with weight_row=w_cnt; w_cnt++.
  - The pop that makes w_cnt reach ARRAY_DIM moves to COMPUTE.
  - When !buf_empty && !buf_is_weight: set err[0], go to ERR with no pop.
- COMPUTE
  - When !buf_empty && !buf_is_weight && credits<OUT_DEPTH: assert buf_pop and array_en; issued++.
  - The issue that makes issued reach the latched job_len moves to DRAIN.
  - A weight word at the head sets err[0] and goes to ERR with no pop.
  - If credits==OUT_DEPTH, the controller stalls with no pop.
- DRAIN: wait until the valid pipeline is empty, then go to DONE.
- DONE: for one cycle, set done, then return to IDLE.
- ERR
  - Hold until clear, then return to IDLE.
  - On entry, flush the valid pipeline (res_capture is suppressed) and pulse out_flush.
- Valid pipeline: a PIPE_LAT-deep shift register of array_en; its output is res_capture. It shifts every cycle in all non-ERR states.
- Credits (0..OUT_DEPTH)
  - +1 on array_en, −1 on out_pop; both in the same cycle leaves credits unchanged.
  - out_pop while credits==0 is ignored, with no underflow.
- busy=1 in LOAD_W, COMPUTE and DRAIN.
- start while busy sets err[2] and is otherwise ignored; the job continues.
- clear in any state:
  - returns the FSM to IDLE;
  - zeroes credits, w_cnt, issued, the pipeline and err;
  - pulses out_flush.
  - done is also cleared.
  - clear has priority over start in the same cycle.
- err bits are sticky until clear. A new start from IDLE does not clear err.

## Timing
- Reset (n_rst=0 at a clk edge):
  - state goes to IDLE; all counters, the pipeline and credits are zeroed;
  - every output is 0, including weight_row.
- buf_pop, weight_load, array_en and weight_row are combinational from state plus buffer/credit inputs, valid in the same cycle as the head word. The buffer updates its head at the next edge.
- Back-to-back operation: one weight or input word per cycle when the buffer is non-empty.
- start→first buf_pop: earliest 1 cycle (start registered into LOAD_W).
- res_capture is asserted exactly PIPE_LAT cycles after the corresponding array_en.
- Last array_en at cycle t: DRAIN exits at t+PIPE_LAT, and done rises at t+PIPE_LAT+2.
- A credit check in cycle t sees credits as registered at the start of t; an out_pop in t frees a slot from t+1.

## Test plan
- Nominal job:
  - Stimulus: ARRAY_DIM=4, job_len=3; preload 4 weight words and 3 input words; out_pop held high.
  - Required: weight_row sequence 0,1,2,3; array_en on 3 consecutive cycles; 3 res_capture pulses each PIPE_LAT after its array_en; done=1; busy=0; err=0.
- Credit stall:
  - Stimulus: OUT_DEPTH=4, job_len=6, out_pop=0.
  - Required: exactly 4 array_en, then a stall with buf_pop=0.
  - Then a single out_pop yields exactly one more array_en one cycle later.
- Tag error:
  - Stimulus: an input word at the head during LOAD_W after 2 weights.
  - Required: err=3'b001, no pop, out_flush pulse, state holds in ERR.
  - Then clear gives err=0 and IDLE.
- Zero-length and busy start:
  - Stimulus: start with job_len=0, then clear, then a normal job with an extra start during COMPUTE.
  - Required: err=3'b010 for the first; for the extra start, err[2] sets and the job still completes with done=1.
- Buffer underrun: empty the buffer mid-COMPUTE for 5 cycles. Required: no pops and no array_en during the gap, then resume; issued count stays exact.
- Reset and clear mid-job:
  - Stimulus: assert n_rst=0 for 1 cycle during DRAIN with 2 results in flight.
  - Required: next cycle all outputs are 0 and no res_capture fires.
  - Repeat with clear instead: out_flush pulses and credits read 0 on the next job.
